// File: rtl/mel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mel_pkg
// Description : Shared types and constants for the streaming mel filterbank:
//               mel/bin counts, the triangle ROM entry layout, the drain FSM
//               state type and the triangle coefficient table.
//               Table layout: 41 segments of 3 bins. Segment s covers bins
//               3s..3s+2. Its rising weights are 1/6, 1/2, 5/6 (mel s) and
//               its falling weights are 5/6, 1/2, 1/6 (mel s-1). Every mel
//               therefore has a total weight of exactly 3.0. Bins 123..128
//               carry no weight.
// Revision    : 1.0 - initial release
// ============================================================================
package mel_pkg;

   localparam int N_MELS    = 40;
   localparam int N_BINS    = 129;
   localparam int WEIGHT_W  = 16;
   localparam int MEL_IDX_W = $clog2(N_MELS);
   localparam int BIN_IDX_W = $clog2(N_BINS);

   typedef struct packed {
      logic [MEL_IDX_W-1:0] mel_a;   // falling-edge mel (rising-edge mel is mel_a+1)
      logic                 en_a;
      logic [WEIGHT_W-1:0]  w_a;
      logic                 en_b;
      logic [WEIGHT_W-1:0]  w_b;
   } tri_entry_t;

   typedef tri_entry_t [N_BINS-1:0] tri_table_t;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

   function automatic tri_table_t build_tri_table();
      tri_table_t          t;
      tri_entry_t          e;
      int                  seg;
      int                  off;
      logic [WEIGHT_W-1:0] r;
      logic [WEIGHT_W-1:0] f;
      for (int k = 0; k < N_BINS; k++) begin
         seg = k / 3;
         off = k % 3;
         r   = (off == 0) ? 16'h2AAB : (off == 1) ? 16'h8000 : 16'hD555;
         f   = (off == 0) ? 16'hD555 : (off == 1) ? 16'h8000 : 16'h2AAB;
         e   = '0;
         if (seg == 0) begin
            // Only the rising edge of mel 0; it sits in lane a.
            e.en_a = 1'b1;
            e.w_a  = r;
         end else if (seg < N_MELS) begin
            e.mel_a = MEL_IDX_W'(seg - 1);
            e.en_a  = 1'b1;
            e.w_a   = f;
            e.en_b  = 1'b1;
            e.w_b   = r;
         end else if (seg == N_MELS) begin
            e.mel_a = MEL_IDX_W'(N_MELS - 1);
            e.en_a  = 1'b1;
            e.w_a   = f;
         end
         t[k] = e;
      end
      return t;
   endfunction

   localparam tri_table_t TRI_TABLE = build_tri_table();

endpackage
`default_nettype wire

// File: rtl/mel_filterbank_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : mel_filterbank_stream_if
// Description : Power-bin input stream and mel output stream of the
//               filterbank. The slave modport is the filterbank side; the
//               master modport is the producer/consumer side.
//   power_i/power_valid_i/power_last_i/power_ready_o : bin input handshake
//   mel_o/mel_idx_o/mel_valid_o/mel_last_o/mel_ready_i/sat_o : mel output
//   frame_err_o : one-cycle frame length mismatch pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mel_filterbank_stream_if #(
   parameter int POWER_W = 31,
   parameter int OUT_W   = 32
);
   import mel_pkg::*;

   logic [POWER_W-1:0]   power_i;
   logic                 power_valid_i;
   logic                 power_last_i;
   logic                 power_ready_o;
   logic [OUT_W-1:0]     mel_o;
   logic [MEL_IDX_W-1:0] mel_idx_o;
   logic                 mel_valid_o;
   logic                 mel_last_o;
   logic                 mel_ready_i;
   logic                 sat_o;
   logic                 frame_err_o;

   modport slave (
      input  power_i, power_valid_i, power_last_i, mel_ready_i,
      output power_ready_o, mel_o, mel_idx_o, mel_valid_o, mel_last_o, sat_o, frame_err_o
   );

   modport master (
      output power_i, power_valid_i, power_last_i, mel_ready_i,
      input  power_ready_o, mel_o, mel_idx_o, mel_valid_o, mel_last_o, sat_o, frame_err_o
   );
endinterface
`default_nettype wire

// File: rtl/mel_tri_rom.sv
`default_nettype none
// ============================================================================
// Module      : mel_tri_rom
// Description : Combinational triangle-coefficient lookup by bin index.
//   bin   : in  BIN_IDX_W  bin counter
//   entry : out            {mel_a, en_a, w_a, en_b, w_b}
// Revision    : 1.0 - initial release
// ============================================================================
module mel_tri_rom
   import mel_pkg::*;
(
   input  logic [BIN_IDX_W-1:0] bin,
   output tri_entry_t           entry
);
   assign entry = TRI_TABLE[bin];
endmodule
`default_nettype wire

// File: rtl/mel_filterbank_stream.sv
`default_nettype none
// ============================================================================
// Module      : mel_filterbank_stream
// Description : Streaming triangular mel filterbank. One power bin per
//               handshake flows through a 3-stage pipeline (register, 2-lane
//               multiply, accumulate). Completed frames are copied into an
//               output buffer that drains one rescaled, saturated mel per
//               handshake.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   bus (slave)     : power input stream, mel output stream, frame_err_o
// Revision    : 1.0 - initial release
// ============================================================================
module mel_filterbank_stream
   import mel_pkg::*;
#(
   parameter int POWER_W   = 31,
   parameter int ACCUM_W   = 54,
   parameter int OUT_W     = 32,
   parameter int OUT_SHIFT = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   mel_filterbank_stream_if.slave bus
);
   localparam int PROD_W = POWER_W + WEIGHT_W;

   logic                 started;
   logic [BIN_IDX_W-1:0] bin_cnt;
   tri_entry_t           rom_entry;

   logic                 s1_valid, s1_copy, s1_drop;
   logic [POWER_W-1:0]   s1_power;
   tri_entry_t           s1_entry;

   logic                 s2_valid, s2_copy, s2_drop;
   logic [MEL_IDX_W-1:0] s2_mel_a;
   logic [PROD_W-1:0]    s2_prod_a, s2_prod_b;

   logic [ACCUM_W-1:0]   acc     [N_MELS];
   logic [ACCUM_W-1:0]   acc_new [N_MELS];
   logic [ACCUM_W-1:0]   obuf    [N_MELS];
   logic [ACCUM_W-1:0]   acc_a, acc_b, sum_a, sum_b, sel, scaled;
   logic [MEL_IDX_W-1:0] mel_b, out_idx;

   drain_state_t         state, state_next;
   logic                 frame_err, buf_full, drain_fire, drain_done;
   logic                 last_bin, frame_end, frame_ok, in_fire, stall, advance, copy, clip;

   mel_tri_rom u_rom (.bin(bin_cnt), .entry(rom_entry));

   assign last_bin  = (bin_cnt == BIN_IDX_W'(N_BINS - 1));
   assign frame_end = bus.power_last_i || last_bin;
   assign frame_ok  = bus.power_last_i && last_bin;

   assign buf_full   = (state == DRAIN);
   assign drain_fire = buf_full && bus.mel_ready_i;
   assign drain_done = drain_fire && (out_idx == MEL_IDX_W'(N_MELS - 1));

   // A good frame end may only enter S3 once the buffer is free (or frees
   // this very cycle); until then the whole pipeline freezes.
   assign stall   = s2_valid && s2_copy && buf_full && !drain_done;
   assign advance = !stall;
   assign copy    = s2_valid && s2_copy && advance;

   // Input closes as soon as a good frame end is in flight behind a full buffer.
   assign bus.power_ready_o = started &&
                              !(buf_full && ((s1_valid && s1_copy) || (s2_valid && s2_copy)));
   assign in_fire = bus.power_valid_i && bus.power_ready_o;

   // Shared 2-lane read of the two accumulators touched by the S2 bin.
   assign mel_b = s2_mel_a + MEL_IDX_W'(1);
   always_comb begin
      acc_a = '0;
      acc_b = '0;
      for (int m = 0; m < N_MELS; m++) begin
         if (s2_mel_a == MEL_IDX_W'(m)) acc_a = acc[m];
         if (mel_b == MEL_IDX_W'(m))    acc_b = acc[m];
      end
   end
   assign sum_a = acc_a + ACCUM_W'(s2_prod_a);
   assign sum_b = acc_b + ACCUM_W'(s2_prod_b);

   always_comb begin
      for (int m = 0; m < N_MELS; m++) begin
         acc_new[m] = acc[m];
         if (s2_mel_a == MEL_IDX_W'(m))  acc_new[m] = sum_a;
         else if (mel_b == MEL_IDX_W'(m)) acc_new[m] = sum_b;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         started   <= 1'b0;
         bin_cnt   <= '0;
         s1_valid  <= 1'b0;
         s1_copy   <= 1'b0;
         s1_drop   <= 1'b0;
         s1_power  <= '0;
         s1_entry  <= '0;
         s2_valid  <= 1'b0;
         s2_copy   <= 1'b0;
         s2_drop   <= 1'b0;
         s2_mel_a  <= '0;
         s2_prod_a <= '0;
         s2_prod_b <= '0;
         frame_err <= 1'b0;
         for (int m = 0; m < N_MELS; m++) begin
            acc[m]  <= '0;
            obuf[m] <= '0;
         end
      end else begin
         started   <= 1'b1;
         frame_err <= advance && s2_valid && s2_drop;
         if (in_fire) bin_cnt <= frame_end ? '0 : bin_cnt + BIN_IDX_W'(1);
         if (advance) begin
            // S1: capture bin, ROM entry and frame-end classification
            s1_valid <= in_fire;
            if (in_fire) begin
               s1_power <= bus.power_i;
               s1_entry <= rom_entry;
               s1_copy  <= frame_ok;
               s1_drop  <= frame_end && !frame_ok;
            end
            // S2: two products, zeroed for disabled lanes
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_mel_a  <= s1_entry.mel_a;
               s2_copy   <= s1_copy;
               s2_drop   <= s1_drop;
               s2_prod_a <= s1_entry.en_a ? PROD_W'(s1_power) * PROD_W'(s1_entry.w_a) : '0;
               s2_prod_b <= s1_entry.en_b ? PROD_W'(s1_power) * PROD_W'(s1_entry.w_b) : '0;
            end
            // S3: accumulate; a frame end also clears, a good one copies out
            if (s2_valid) begin
               for (int m = 0; m < N_MELS; m++) begin
                  acc[m] <= (s2_copy || s2_drop) ? '0 : acc_new[m];
                  if (s2_copy) obuf[m] <= acc_new[m];
               end
            end
         end
      end
   end

   // Drain FSM
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= EMPTY;
         out_idx <= '0;
      end else begin
         state <= state_next;
         if (copy || drain_done) out_idx <= '0;
         else if (drain_fire)    out_idx <= out_idx + MEL_IDX_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (copy) state_next = DRAIN;
         DRAIN:   if (drain_done && !copy) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // Output rescale/saturate on the selected buffer entry
   always_comb begin
      sel = '0;
      for (int m = 0; m < N_MELS; m++) begin
         if (out_idx == MEL_IDX_W'(m)) sel = obuf[m];
      end
   end
   assign scaled = sel >> OUT_SHIFT;
   assign clip   = (scaled >> OUT_W) != '0;

   assign bus.mel_valid_o = buf_full;
   assign bus.mel_idx_o   = buf_full ? out_idx : '0;
   assign bus.mel_o       = !buf_full ? '0 : (clip ? '1 : scaled[OUT_W-1:0]);
   assign bus.sat_o       = buf_full && clip;
   assign bus.mel_last_o  = buf_full && (out_idx == MEL_IDX_W'(N_MELS - 1));
   assign bus.frame_err_o = frame_err;

endmodule
`default_nettype wire

// File: tb/tb_mel_filterbank_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mel_filterbank_stream
// Description : Scoreboard bench for mel_filterbank_stream. Frames are
//               driven with directed patterns whose mel energies are known
//               by hand (every mel has total weight 3.0):
//                 constant P      -> every mel = 3P (saturates above 2^32-1)
//                 impulse bin 10  -> mel 2 = mel 3 = 0x8000
//                 edge frame      -> mel 0 = 0x8001, mel 39 = 0x2AAB
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mel_filterbank_stream;

   typedef struct packed {
      logic [31:0] val;
      logic [5:0]  idx;
      logic        sat;
      logic        last;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   err_seen = 0;
   exp_t sb_q[$];

   mel_filterbank_stream_if #(.POWER_W(31), .OUT_W(32)) bus ();

   mel_filterbank_stream dut (
      .clk_i   (clk),
      .reset_ni(rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [30:0] bin_val(input int kind, input logic [30:0] p, input int k);
      case (kind)
         0:       return p;
         1:       return (k == 10) ? 31'h10000 : 31'h0;
         default: return (k == 0) ? 31'h30000 : (k == 122) ? 31'h10000 :
                         (k >= 123) ? 31'h7FFFFFFF : 31'h0;
      endcase
   endfunction

   task automatic push_frame(input int kind, input logic [30:0] p);
      for (int m = 0; m < 40; m++) begin
         exp_t        e;
         logic [63:0] y;
         case (kind)
            0:       y = 64'(p) * 64'd3;
            1:       y = (m == 2 || m == 3) ? 64'h8000 : 64'h0;
            default: y = (m == 0) ? 64'h8001 : (m == 39) ? 64'h2AAB : 64'h0;
         endcase
         e.sat  = (y > 64'hFFFF_FFFF);
         e.val  = e.sat ? 32'hFFFF_FFFF : y[31:0];
         e.idx  = 6'(m);
         e.last = (m == 39);
         sb_q.push_back(e);
      end
   endtask

   task automatic send_bin(input logic [30:0] v, input logic last);
      int guard;
      guard = 0;
      bus.power_i       = v;
      bus.power_valid_i = 1'b1;
      bus.power_last_i  = last;
      @(negedge clk);
      while (!bus.power_ready_o) begin
         guard++;
         if (guard > 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_bin_timeout: power_ready_o stuck at 0, required 1");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "input stalled");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   // last_at < 0: no power_last_i in the frame
   task automatic send_frame(input int kind, input logic [30:0] p, input int n, input int last_at);
      for (int k = 0; k < n; k++) send_bin(bin_val(kind, p, k), (k == last_at));
      bus.power_valid_i = 1'b0;
      bus.power_last_i  = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int cyc;
      cyc = 0;
      while (sb_q.size() != 0 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      check(name, 64'(sb_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented mel against the scoreboard head
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.frame_err_o) err_seen++;
            if (bus.mel_valid_o) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_mel: idx %0d value %0h, nothing expected",
                           bus.mel_idx_o, bus.mel_o);
               end else begin
                  e = sb_q[0];
                  check("mel_value", 64'(bus.mel_o), 64'(e.val));
                  check("mel_idx", 64'(bus.mel_idx_o), 64'(e.idx));
                  check("mel_sat", 64'(bus.sat_o), 64'(e.sat));
                  check("mel_last", 64'(bus.mel_last_o), 64'(e.last));
                  if (bus.mel_ready_i) e = sb_q.pop_front();
               end
            end
         end
      end
   end

   initial begin : stim
      int guard;
      // Reset with a valid bin pending: nothing may be accumulated
      rst_n             = 1'b0;
      bus.power_i       = 31'h7FFFFFFF;
      bus.power_valid_i = 1'b1;
      bus.power_last_i  = 1'b1;
      bus.mel_ready_i   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", 64'(bus.power_ready_o), 64'd0);
      check("valid_in_reset", 64'(bus.mel_valid_o), 64'd0);
      rst_n             = 1'b1;
      bus.power_valid_i = 1'b0;
      bus.power_last_i  = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", 64'(bus.power_ready_o), 64'd1);
      check("valid_after_reset", 64'(bus.mel_valid_o), 64'd0);
      check("err_after_reset", 64'(bus.frame_err_o), 64'd0);

      // Directed frames, downstream always ready
      push_frame(1, 31'h0);
      send_frame(1, 31'h0, 129, 128);
      wait_empty("impulse_drained");
      push_frame(2, 31'h0);
      push_frame(0, 31'd1000);
      push_frame(0, 31'h55555555);
      push_frame(0, 31'h7FFFFFFF);
      send_frame(2, 31'h0, 129, 128);
      send_frame(0, 31'd1000, 129, 128);
      send_frame(0, 31'h55555555, 129, 128);
      send_frame(0, 31'h7FFFFFFF, 129, 128);
      wait_empty("patterns_drained");
      check("no_err_good_frames", 64'(err_seen), 64'd0);

      // Backpressure: two frames with the output blocked
      bus.mel_ready_i = 1'b0;
      push_frame(0, 31'd7);
      push_frame(1, 31'h0);
      send_frame(0, 31'd7, 129, 128);
      send_frame(1, 31'h0, 129, 128);
      repeat (5) begin
         @(negedge clk);
         check("ready_low_when_full", 64'(bus.power_ready_o), 64'd0);
         check("valid_held", 64'(bus.mel_valid_o), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.mel_ready_i = 1'b1;
      wait_empty("backpressure_drained");
      @(negedge clk);
      check("ready_after_drain", 64'(bus.power_ready_o), 64'd1);
      check("valid_after_drain", 64'(bus.mel_valid_o), 64'd0);

      // Length mismatches: early last, then a full frame without last
      send_frame(0, 31'd1000, 51, 50);
      send_frame(0, 31'd1000, 129, -1);
      push_frame(1, 31'h0);
      send_frame(1, 31'h0, 129, 128);
      wait_empty("after_err_drained");
      check("frame_err_pulses", 64'(err_seen), 64'd2);

      // Reset in the middle of a drain at idx 17
      push_frame(0, 31'd1000);
      send_frame(0, 31'd1000, 129, 128);
      guard = 0;
      while (!(bus.mel_valid_o && bus.mel_idx_o == 6'd17) && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("reached_idx17", 64'(bus.mel_idx_o), 64'd17);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("valid_in_mid_reset", 64'(bus.mel_valid_o), 64'd0);
      check("idx_in_mid_reset", 64'(bus.mel_idx_o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_mid_reset", 64'(bus.power_ready_o), 64'd1);
      push_frame(1, 31'h0);
      send_frame(1, 31'h0, 129, 128);
      wait_empty("post_reset_drained");
      check("frame_err_total", 64'(err_seen), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
